// File: rtl/aurora_frame_check.sv
// rtl/aurora_frame_check.sv - Aurora RX frame checker: header, tkeep and LFSR payload checks.
// Optional header sequence checking is enabled by defining FRAME_CHECK_SEQ_EN.
module aurora_frame_check #(
    parameter logic [7:0]  HDR_TAG   = 8'hA5,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic        USER_CLK,
    input  logic        RESET,
    input  logic        CHANNEL_UP,
    input  logic [0:31] RX_D,
    input  logic        RX_TVALID,
    input  logic [0:3]  RX_TKEEP,
    input  logic        RX_TLAST,
    output logic        DATA_ERR,
    output logic        FRAME_ERR,
    output logic [0:7]  ERR_COUNT,
    output logic [15:0] FRAME_COUNT,
    output logic        CHECK_ACTIVE
);
    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_PAYLOAD = 1'b1;
    // x^22 + x^2 + x + 1 feedback taps of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS  = 32'h0040_0007;

    logic [0:0]  state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [31:0] rx_word;
    logic [31:0] keep_mask;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;
    logic        data_err_q;
    logic        frame_err_q;
    logic        beat;
    logic        hdr_err;
    logic        keep_err;
    logic        data_mis;
    logic        seq_err;
    logic        data_err_d;
    logic        frame_err_d;
    logic [8:0]  err_sum;

    // RX_D[0] lands in rx_word[31], so byte 0 is the most significant byte
    assign rx_word   = RX_D;
    assign beat      = RX_TVALID & CHANNEL_UP;
    assign lfsr_next = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? LFSR_TAPS : 32'h0);
    assign keep_mask = {{8{RX_TKEEP[0]}}, {8{RX_TKEEP[1]}}, {8{RX_TKEEP[2]}}, {8{RX_TKEEP[3]}}};
    assign data_mis  = |((rx_word ^ lfsr) & keep_mask);

`ifdef FRAME_CHECK_SEQ_EN
    logic [15:0] exp_seq;

    assign seq_err = (rx_word[15:0] != exp_seq);

    // Resynchronise to the received sequence so one lost frame costs one error
    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            exp_seq <= 16'h0000;
        end else if (!CHANNEL_UP) begin
            exp_seq <= 16'h0000;
        end else if (beat && state == ST_IDLE) begin
            exp_seq <= rx_word[15:0] + 16'h0001;
        end
    end
`else
    logic unused_seq;

    assign unused_seq = ^rx_word[15:0];
    assign seq_err    = 1'b0;
`endif

    assign hdr_err = (rx_word[31:24] != HDR_TAG) || (rx_word[23:16] != 8'h00) ||
                     (RX_TKEEP != 4'hF) || RX_TLAST || seq_err;

    always_comb begin
        keep_err = 1'b0;
        if (RX_TLAST) begin
            keep_err = !((RX_TKEEP == 4'h8) || (RX_TKEEP == 4'hC) ||
                         (RX_TKEEP == 4'hE) || (RX_TKEEP == 4'hF));
        end else begin
            keep_err = (RX_TKEEP != 4'hF);
        end
    end

    always_comb begin
        data_err_d  = 1'b0;
        frame_err_d = 1'b0;
        if (beat) begin
            if (state == ST_IDLE) begin
                frame_err_d = hdr_err;
            end else begin
                frame_err_d = keep_err;
                data_err_d  = data_mis;
            end
        end
        err_sum = {1'b0, err_cnt} + {8'h00, data_err_d} + {8'h00, frame_err_d};
    end

    always_ff @(posedge USER_CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            lfsr        <= LFSR_SEED;
            err_cnt     <= 8'h00;
            frame_cnt   <= 16'h0000;
            data_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            data_err_q  <= data_err_d;
            frame_err_q <= frame_err_d;
            err_cnt     <= err_sum[8] ? 8'hFF : err_sum[7:0];
            // A dropped channel abandons the frame silently; counters hold
            if (!CHANNEL_UP) begin
                state <= ST_IDLE;
                lfsr  <= LFSR_SEED;
            end else if (beat) begin
                if (state == ST_IDLE) begin
                    if (!RX_TLAST) begin
                        state <= ST_PAYLOAD;
                    end
                end else begin
                    lfsr <= lfsr_next;
                    if (RX_TLAST) begin
                        state     <= ST_IDLE;
                        frame_cnt <= frame_cnt + 16'h0001;
                    end
                end
            end
        end
    end

    assign DATA_ERR     = data_err_q;
    assign FRAME_ERR    = frame_err_q;
    assign ERR_COUNT    = err_cnt;
    assign FRAME_COUNT  = frame_cnt;
    assign CHECK_ACTIVE = (state == ST_PAYLOAD);

endmodule

// File: tb/tb_aurora_frame_check.sv
// tb/tb_aurora_frame_check.sv - directed scoreboard bench for aurora_frame_check.
module tb_aurora_frame_check;
    localparam logic [7:0]  TAG  = 8'hA5;
    localparam logic [31:0] SEED = 32'h0000_0001;
`ifdef FRAME_CHECK_SEQ_EN
    localparam logic SEQ_ON = 1'b1;
`else
    localparam logic SEQ_ON = 1'b0;
`endif

    logic        USER_CLK   = 1'b0;
    logic        RESET      = 1'b1;
    logic        CHANNEL_UP = 1'b0;
    logic [0:31] RX_D       = '0;
    logic        RX_TVALID  = 1'b0;
    logic [0:3]  RX_TKEEP   = '0;
    logic        RX_TLAST   = 1'b0;
    logic        DATA_ERR;
    logic        FRAME_ERR;
    logic [0:7]  ERR_COUNT;
    logic [15:0] FRAME_COUNT;
    logic        CHECK_ACTIVE;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  sb[$];
    logic [31:0] m_lfsr   = SEED;
    int          m_err    = 0;
    int          m_frames = 0;

    always #5 USER_CLK = ~USER_CLK;

    aurora_frame_check #(.HDR_TAG(TAG), .LFSR_SEED(SEED)) dut (
        .USER_CLK    (USER_CLK),
        .RESET       (RESET),
        .CHANNEL_UP  (CHANNEL_UP),
        .RX_D        (RX_D),
        .RX_TVALID   (RX_TVALID),
        .RX_TKEEP    (RX_TKEEP),
        .RX_TLAST    (RX_TLAST),
        .DATA_ERR    (DATA_ERR),
        .FRAME_ERR   (FRAME_ERR),
        .ERR_COUNT   (ERR_COUNT),
        .FRAME_COUNT (FRAME_COUNT),
        .CHECK_ACTIVE(CHECK_ACTIVE)
    );

    // Multiply by x modulo x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
        logic        fb;
        logic [31:0] r;
        fb    = v[31];
        r     = v << 1;
        r[0]  = r[0] ^ fb;
        r[1]  = r[1] ^ fb;
        r[2]  = r[2] ^ fb;
        r[22] = r[22] ^ fb;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic vld, input logic [31:0] d, input logic [3:0] keep,
                        input logic last, input logic ed, input logic ef);
        logic [1:0] e;
        @(negedge USER_CLK);
        RX_TVALID = vld;
        RX_D      = d;
        RX_TKEEP  = keep;
        RX_TLAST  = last;
        sb.push_back({ed, ef});
        m_err = m_err + int'(ed) + int'(ef);
        if (m_err > 255) m_err = 255;
        @(posedge USER_CLK);
        #1;
        RX_TVALID = 1'b0;
        e = sb.pop_front();
        chk("data_err", {31'b0, DATA_ERR}, {31'b0, e[1]});
        chk("frame_err", {31'b0, FRAME_ERR}, {31'b0, e[0]});
    endtask

    task automatic hdr(input logic [15:0] seq, input logic last, input logic ef);
        step(1'b1, {TAG, 8'h00, seq}, 4'hF, last, 1'b0, ef);
    endtask

    task automatic pay(input logic last, input logic [3:0] keep, input logic [31:0] flip,
                       input logic ed, input logic ef);
        step(1'b1, m_lfsr ^ flip, keep, last, ed, ef);
        m_lfsr = lfsr_adv(m_lfsr);
        if (last) m_frames++;
    endtask

    task automatic good_frame(input logic [15:0] seq, input int beats);
        hdr(seq, 1'b0, 1'b0);
        for (int i = 0; i < beats; i++) pay(i == beats - 1, 4'hF, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_err_count"}, {24'b0, ERR_COUNT}, m_err);
        chk({tag, "_frame_count"}, {16'b0, FRAME_COUNT}, m_frames);
    endtask

    initial begin
        repeat (2) @(negedge USER_CLK);
        #1;
        chk("rst_data_err", {31'b0, DATA_ERR}, 32'd0);
        chk("rst_frame_err", {31'b0, FRAME_ERR}, 32'd0);
        chk("rst_check_active", {31'b0, CHECK_ACTIVE}, 32'd0);
        chk_counts("rst");
        @(negedge USER_CLK);
        RESET      = 1'b0;
        CHANNEL_UP = 1'b1;

        // three clean frames
        hdr(16'd0, 1'b0, 1'b0);
        chk("active_after_hdr", {31'b0, CHECK_ACTIVE}, 32'd1);
        for (int i = 0; i < 4; i++) pay(i == 3, 4'hF, 32'h0, 1'b0, 1'b0);
        good_frame(16'd1, 4);
        good_frame(16'd2, 4);
        chk("idle_after_frames", {31'b0, CHECK_ACTIVE}, 32'd0);
        chk_counts("clean");
        chk("clean_frames_3", {16'b0, FRAME_COUNT}, 32'd3);

        // last byte of second payload beat corrupted
        hdr(16'd3, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0000_00FF, 1'b1, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        pay(1'b1, 4'hF, 32'h0, 1'b0, 1'b0);
        chk("data_err_count_1", {24'b0, ERR_COUNT}, 32'd1);

        // partial last beats
        hdr(16'd4, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        pay(1'b1, 4'hC, 32'h0000_FFFF, 1'b0, 1'b0);
        hdr(16'd5, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        pay(1'b1, 4'h5, 32'h0000_FF00, 1'b0, 1'b1);
        chk("keep5_err_count", {24'b0, ERR_COUNT}, 32'd2);
        hdr(16'd6, 1'b0, 1'b0);
        pay(1'b1, 4'h5, 32'h0000_FFFF, 1'b1, 1'b1);
        chk("double_err_count", {24'b0, ERR_COUNT}, 32'd4);

        // bad header tag, then a non-full tkeep on a middle beat
        step(1'b1, {8'h5A, 8'h00, 16'd7}, 4'hF, 1'b0, 1'b0, 1'b1);
        pay(1'b1, 4'hF, 32'h0, 1'b0, 1'b0);
        hdr(16'd8, 1'b0, 1'b0);
        pay(1'b0, 4'hE, 32'h0, 1'b0, 1'b1);
        pay(1'b1, 4'hE, 32'h0000_00FF, 1'b0, 1'b0);
        chk_counts("hdr_keep");

        // channel drop mid-frame
        hdr(16'd9, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        CHANNEL_UP = 1'b0;
        step(1'b1, 32'hDEAD_BEEF, 4'h3, 1'b1, 1'b0, 1'b0);
        chk("drop_idle", {31'b0, CHECK_ACTIVE}, 32'd0);
        CHANNEL_UP = 1'b1;
        m_lfsr = SEED;
        good_frame(16'd0, 3);
        chk_counts("chan_drop");

        // sequence gap 0 -> 2 -> 3
        hdr(16'd2, 1'b0, SEQ_ON);
        pay(1'b1, 4'hF, 32'h0, 1'b0, 1'b0);
        good_frame(16'd3, 1);
        chk_counts("seq_gap");

        // single-beat frame is a short-frame error and stays idle
        hdr(16'd4, 1'b1, 1'b1);
        chk("short_idle", {31'b0, CHECK_ACTIVE}, 32'd0);
        hdr(16'd5, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) pay(1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        pay(1'b1, 4'hF, 32'h0, 1'b0, 1'b0);
        chk("err_saturated", {24'b0, ERR_COUNT}, 32'hFF);
        chk_counts("saturate");

        // reset in the middle of a frame
        hdr(16'd6, 1'b0, 1'b0);
        pay(1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        @(negedge USER_CLK);
        RESET = 1'b1;
        #1;
        m_err    = 0;
        m_frames = 0;
        m_lfsr   = SEED;
        chk("mid_rst_active", {31'b0, CHECK_ACTIVE}, 32'd0);
        chk_counts("mid_rst");
        @(negedge USER_CLK);
        RESET = 1'b0;
        good_frame(16'd0, 2);
        chk_counts("post_rst");
        chk("post_rst_frames_1", {16'b0, FRAME_COUNT}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
